// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: load-size masks and FSM states.
package wb_stage_pkg;

   localparam logic [3:0] LS_B = 4'b0001;
   localparam logic [3:0] LS_H = 4'b0011;
   localparam logic [3:0] LS_W = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction: shift by the byte offset, mask to the access size,
// then sign- or zero-extend.
module load_align
   import wb_stage_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  data_addr,
   input  logic [3:0]  lsV,
   input  logic        loadX,
   output logic [31:0] data
);

   logic [31:0] shifted_s;

   // shift, mask and extend
   always_comb begin
      shifted_s = raw >> {data_addr, 3'b000};
      case (lsV)
         LS_B: begin
            if (loadX) begin
               data = {24'h00_0000, shifted_s[7:0]};
            end else begin
               data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
         end
         LS_H: begin
            if (loadX) begin
               data = {16'h0000, shifted_s[15:0]};
            end else begin
               data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
         end
         LS_W:    data = shifted_s;
         default: data = shifted_s;
      endcase
   end

endmodule

// File: rtl/wb_stage_chk.sv
// Protocol checker: no undropped load response may arrive while data is held.
module wb_stage_chk (
   input logic clk,
   input logic resetn,
   input logic hold,
   input logic data_ok,
   input logic drop_zero
);

   a_no_resp_in_hold: assert property (@(posedge clk) disable iff (!resetn)
      !(hold && data_ok && drop_zero));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load response tracking, cancelled-response dropping,
// write-back source selection and the single register-file write per instruction.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int MAX_DROP = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic        wb_adv,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_res,
   input  logic        wb_load,
   input  logic        wb_loadX,
   input  logic [3:0]  wb_lsV,
   input  logic [1:0]  wb_data_addr,
   input  logic        wb_al,
   input  logic        wb_regwen,
   input  logic [4:0]  wb_wreg,
   input  logic        wb_cp0ren,
   input  logic [31:0] wb_cp0rdata,
   input  logic [1:0]  wb_hiloren,
   input  logic [31:0] wb_hilordata,
   input  logic        drop_req,
   input  logic        data_ok,
   input  logic [31:0] data_rdata,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        wb_stall_req,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   localparam int DW = $clog2(MAX_DROP + 1);

   wb_state_e   state_r, state_nxt_s;
   logic [DW-1:0] drop_cnt_r;
   logic [31:0] buffer_r;
   logic        committed_r;
   logic        drop_zero_s, swallow_s, ld_hit_s, hold_s, capture_s;
   logic [31:0] raw_s, load_data_s;

   assign drop_zero_s  = (drop_cnt_r == '0);
   assign swallow_s    = data_ok & ~drop_zero_s;
   assign hold_s       = (state_r == ST_HOLD);
   assign ld_hit_s     = data_ok & drop_zero_s & wb_valid & wb_load & ~hold_s;
   assign capture_s    = ld_hit_s & ~wb_adv;
   assign wb_stall_req = wb_valid & wb_load & ~(ld_hit_s | hold_s);
   assign raw_s        = ld_hit_s ? data_rdata : buffer_r;

   load_align u_align (
      .raw       (raw_s),
      .data_addr (wb_data_addr),
      .lsV       (wb_lsV),
      .loadX     (wb_loadX),
      .data      (load_data_s)
   );

   // next-state selection
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (capture_s) begin
               state_nxt_s = ST_HOLD;
            end else if (wb_valid && wb_load && !ld_hit_s) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (ld_hit_s && wb_adv) begin
               state_nxt_s = ST_IDLE;
            end else if (capture_s) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (wb_adv) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // state, drop counter, load buffer and write-once flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         drop_cnt_r  <= '0;
         buffer_r    <= 32'h0000_0000;
         committed_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         // a new cancellation and a swallowed response in one cycle cancel out
         if (drop_req && !swallow_s) begin
            if (drop_cnt_r < DW'(MAX_DROP)) begin
               drop_cnt_r <= drop_cnt_r + DW'(1);
            end
         end else if (!drop_req && swallow_s) begin
            drop_cnt_r <= drop_cnt_r - DW'(1);
         end
         if (capture_s) begin
            buffer_r <= data_rdata;
         end
         if (wb_adv) begin
            committed_r <= 1'b0;
         end else if (rf_wen) begin
            committed_r <= 1'b1;
         end
      end
   end

   // write enable and write-back source priority
   always_comb begin
      rf_wen = wb_valid & wb_regwen & (wb_wreg != 5'd0) & ~committed_r & ~wb_stall_req;
      if (wb_load) begin
         rf_wdata = load_data_s;
      end else if (wb_cp0ren) begin
         rf_wdata = wb_cp0rdata;
      end else if (wb_hiloren != 2'b00) begin
         rf_wdata = wb_hilordata;
      end else if (wb_al) begin
         rf_wdata = wb_res;
      end else begin
         rf_wdata = wb_res;
      end
   end

   assign rf_waddr          = wb_wreg;
   assign debug_wb_pc       = wb_pc;
   assign debug_wb_rf_wen   = {4{rf_wen}};
   assign debug_wb_rf_wnum  = wb_wreg;
   assign debug_wb_rf_wdata = rf_wdata;

   wb_stage_chk u_chk (
      .clk       (clk),
      .resetn    (resetn),
      .hold      (hold_s),
      .data_ok   (data_ok),
      .drop_zero (drop_zero_s)
   );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed load/drop/stall scenarios; expected
// writes are queued by the stimulus and popped by a negedge monitor.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wb_valid, wb_adv, wb_load, wb_loadX, wb_al, wb_regwen, wb_cp0ren;
   logic [31:0] wb_pc, wb_res, wb_cp0rdata, wb_hilordata, data_rdata;
   logic [3:0]  wb_lsV;
   logic [1:0]  wb_data_addr, wb_hiloren;
   logic [4:0]  wb_wreg;
   logic        drop_req, data_ok;
   logic        rf_wen, wb_stall_req;
   logic [4:0]  rf_waddr, debug_wb_rf_wnum;
   logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]  debug_wb_rf_wen;

   typedef struct {
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk (clk), .resetn (resetn),
      .wb_valid (wb_valid), .wb_adv (wb_adv), .wb_pc (wb_pc), .wb_res (wb_res),
      .wb_load (wb_load), .wb_loadX (wb_loadX), .wb_lsV (wb_lsV),
      .wb_data_addr (wb_data_addr), .wb_al (wb_al), .wb_regwen (wb_regwen),
      .wb_wreg (wb_wreg), .wb_cp0ren (wb_cp0ren), .wb_cp0rdata (wb_cp0rdata),
      .wb_hiloren (wb_hiloren), .wb_hilordata (wb_hilordata),
      .drop_req (drop_req), .data_ok (data_ok), .data_rdata (data_rdata),
      .rf_wen (rf_wen), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
      .wb_stall_req (wb_stall_req), .debug_wb_pc (debug_wb_pc),
      .debug_wb_rf_wen (debug_wb_rf_wen), .debug_wb_rf_wnum (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, act, exp);
      end
   endtask

   task automatic clear_instr();
      wb_valid = 1'b0; wb_adv = 1'b1; wb_pc = 32'h0; wb_res = 32'h0;
      wb_load = 1'b0; wb_loadX = 1'b0; wb_lsV = 4'b1111; wb_data_addr = 2'b00;
      wb_al = 1'b0; wb_regwen = 1'b0; wb_wreg = 5'd0; wb_cp0ren = 1'b0;
      wb_cp0rdata = 32'h0; wb_hiloren = 2'b00; wb_hilordata = 32'h0;
      drop_req = 1'b0; data_ok = 1'b0; data_rdata = 32'h0;
   endtask

   task automatic load_instr(input logic [31:0] pc, input logic [4:0] wreg, input logic [3:0] lsv,
                             input logic [1:0] addr, input logic zx);
      clear_instr();
      wb_valid = 1'b1; wb_pc = pc; wb_load = 1'b1; wb_regwen = 1'b1; wb_wreg = wreg;
      wb_lsV = lsv; wb_data_addr = addr; wb_loadX = zx; wb_res = 32'h5A5A_5A5A;
   endtask

   task automatic push(input logic [4:0] waddr, input logic [31:0] wdata, input logic [31:0] pc);
      exp_t e;
      e.waddr = waddr; e.wdata = wdata; e.pc = pc;
      sb_q.push_back(e);
   endtask

   // one clock: check write enable / stall (and optionally data) at negedge
   task automatic cycle(input logic exp_wen, input logic exp_stall, input logic chk_data,
                        input logic [31:0] exp_data, input string name);
      @(negedge clk);
      chk({name, "_wen"}, {31'h0, rf_wen}, {31'h0, exp_wen});
      chk({name, "_stall"}, {31'h0, wb_stall_req}, {31'h0, exp_stall});
      if (chk_data) chk({name, "_wdata"}, rf_wdata, exp_data);
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (resetn) begin
         chk("dbg_wen_mirror", {28'h0, debug_wb_rf_wen}, {28'h0, {4{rf_wen}}});
         if (rf_wen) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write got waddr %0d wdata %h exp none", rf_waddr, rf_wdata);
            end else begin
               mon_e = sb_q.pop_front();
               chk("sb_waddr", {27'h0, rf_waddr}, {27'h0, mon_e.waddr});
               chk("sb_wdata", rf_wdata, mon_e.wdata);
               chk("sb_dbg_pc", debug_wb_pc, mon_e.pc);
               chk("sb_dbg_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, mon_e.waddr});
               chk("sb_dbg_wdata", debug_wb_rf_wdata, mon_e.wdata);
            end
         end
      end
   end

   initial begin
      clear_instr();
      resetn = 1'b0;
      @(negedge clk);
      chk("reset_wen", {31'h0, rf_wen}, 32'h0);
      chk("reset_stall", {31'h0, wb_stall_req}, 32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "idle");

      // lb, addr 2, zero-latency response, sign-extended
      load_instr(32'h0000_0100, 5'd5, 4'b0001, 2'b10, 1'b0);
      data_ok = 1'b1; data_rdata = 32'h1280_3456;
      push(5'd5, 32'hFFFF_FF80, 32'h0000_0100);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, "lb_zero_lat");

      // lhu, addr 2, response 3 cycles late
      load_instr(32'h0000_0104, 5'd6, 4'b0011, 2'b10, 1'b1);
      wb_adv = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, "lhu_wait");
      data_ok = 1'b1; data_rdata = 32'h8001_0000; wb_adv = 1'b1;
      push(5'd6, 32'h0000_8001, 32'h0000_0104);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, "lhu_late");

      // lw under 4-cycle external stall: buffered, single write
      load_instr(32'h0000_0108, 5'd7, 4'b1111, 2'b00, 1'b0);
      wb_adv = 1'b0; data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
      push(5'd7, 32'hDEAD_BEEF, 32'h0000_0108);
      cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, "lw_hold_first");
      data_ok = 1'b0; data_rdata = 32'h0000_0000;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, "lw_hold");
      wb_adv = 1'b1;
      cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, "lw_hold_adv");

      // two cancelled loads, then lw: responses A and B swallowed, C written
      clear_instr();
      drop_req = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "drop1");
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "drop2");
      load_instr(32'h0000_010C, 5'd9, 4'b1111, 2'b00, 1'b0);
      wb_adv = 1'b0; data_ok = 1'b1; data_rdata = 32'h1111_1111;
      cycle(1'b0, 1'b1, 1'b0, 32'h0, "drop_swallow_a");
      data_rdata = 32'h2222_2222;
      cycle(1'b0, 1'b1, 1'b0, 32'h0, "drop_swallow_b");
      data_rdata = 32'hCAFE_F00D; wb_adv = 1'b1;
      push(5'd9, 32'hCAFE_F00D, 32'h0000_010C);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, "drop_c_written");
      // drop counter back at zero: lh hits immediately, sign-extended half
      load_instr(32'h0000_0110, 5'd10, 4'b0011, 2'b00, 1'b0);
      data_ok = 1'b1; data_rdata = 32'h0000_8765;
      push(5'd10, 32'hFFFF_8765, 32'h0000_0110);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, "lh_after_drop");

      // addu to r0: no write
      clear_instr();
      wb_valid = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd0; wb_res = 32'h0000_0055; wb_pc = 32'h0000_0114;
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "addu_r0");
      // mfc0 r8 under 2-cycle external stall
      clear_instr();
      wb_valid = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd8; wb_pc = 32'h0000_0118;
      wb_cp0ren = 1'b1; wb_cp0rdata = 32'h0000_1234; wb_res = 32'h0000_9999; wb_adv = 1'b0;
      push(5'd8, 32'h0000_1234, 32'h0000_0118);
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_1234, "mfc0_first");
      cycle(1'b0, 1'b0, 1'b1, 32'h0000_1234, "mfc0_stall");
      wb_adv = 1'b1;
      cycle(1'b0, 1'b0, 1'b1, 32'h0000_1234, "mfc0_adv");
      // mfhi and jal sources
      clear_instr();
      wb_valid = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd11; wb_pc = 32'h0000_011C;
      wb_hiloren = 2'b01; wb_hilordata = 32'hABCD_0001; wb_res = 32'h0000_7777;
      push(5'd11, 32'hABCD_0001, 32'h0000_011C);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, "mfhi");
      clear_instr();
      wb_valid = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd31; wb_pc = 32'h0000_0120;
      wb_al = 1'b1; wb_res = 32'h0000_0128;
      push(5'd31, 32'h0000_0128, 32'h0000_0120);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, "jal");

      // reset in WAIT with two drops pending
      clear_instr();
      drop_req = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "rst_drop1");
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "rst_drop2");
      load_instr(32'h0000_0130, 5'd12, 4'b1111, 2'b00, 1'b0);
      wb_adv = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 32'h0, "rst_wait");
      resetn = 1'b0;
      clear_instr();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "rst_mid_wait");
      resetn = 1'b1;
      load_instr(32'h0000_0134, 5'd13, 4'b1111, 2'b00, 1'b0);
      data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
      push(5'd13, 32'h0BAD_F00D, 32'h0000_0134);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, "post_rst_hit");
      clear_instr();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, "final_idle");

      chk("sb_empty", sb_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
